neuron_layer_sequencer: RTL

Initiator-side controller for the CORDIC neuron datapath. It holds an input vector, a weight matrix and biases. It runs one neuron pass per output: reset the neuron, stream (input, weight) beats with bias, then enable the activation and wait for completion. It captures each activation result into a result buffer. It sits between the host/config logic and the neuron + activation block, and turns a single neuron into a sequential N_OUT-wide layer.

---
 rtl/neuron_layer_sequencer_pkg.sv | 28 ++
 rtl/seq_param_mem.sv | 55 +++++
 rtl/neuron_layer_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/neuron_layer_sequencer_pkg.sv
// rtl/neuron_layer_sequencer_pkg.sv - shared encodings for the neuron layer sequencer
package neuron_layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NRST,
        ST_FEED,
        ST_WAIT,
        ST_STORE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CFG_INPUT  = 2'b00,
        CFG_WEIGHT = 2'b01,
        CFG_BIAS   = 2'b10,
        CFG_NONE   = 2'b11
    } cfg_sel_t;

    typedef enum logic [1:0] {
        AF_SIGMOID = 2'b00,
        AF_TANH    = 2'b01,
        AF_RELU    = 2'b10
    } af_sel_t;

    localparam logic [15:0] ONE = 16'h0400;

endpackage

// File: rtl/seq_param_mem.sv
// rtl/seq_param_mem.sv - input/weight/bias register storage with config write and one read port
module seq_param_mem
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int N_IN  = 8,
    parameter int N_OUT = 4,
    localparam int AW   = $clog2(N_IN * N_OUT),
    localparam int JW   = $clog2(N_OUT),
    localparam int KW   = $clog2(N_IN)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [1:0]     sel,
    input  logic [AW-1:0]  addr,
    input  logic [WIDTH:0] data,
    input  logic [JW-1:0]  rd_neuron,
    input  logic [KW-1:0]  rd_beat,
    output logic [WIDTH:0] rd_x,
    output logic [WIDTH:0] rd_w,
    output logic [WIDTH:0] rd_b
);

    logic [WIDTH:0] in_mem [N_IN];
    logic [WIDTH:0] w_mem  [N_IN*N_OUT];
    logic [WIDTH:0] b_mem  [N_OUT];
    logic [31:0]    widx;

    always_ff @(posedge clk) begin
        if (we) begin
            case (sel)
                CFG_INPUT:  if (int'(addr) < N_IN) in_mem[addr[KW-1:0]] <= data;
                CFG_WEIGHT: if (int'(addr) < N_IN * N_OUT) w_mem[addr] <= data;
                CFG_BIAS:   if (int'(addr) < N_OUT) b_mem[addr[JW-1:0]] <= data;
                default: ;
            endcase
        end
    end

    // A write in the same cycle as the read is forwarded, so a run started
    // alongside a config write sees the new value.
    always_comb begin
        widx = 32'(rd_neuron) * 32'(N_IN) + 32'(rd_beat);
        rd_x = '0;
        rd_w = '0;
        rd_b = '0;
        if (int'(rd_beat) < N_IN) rd_x = in_mem[rd_beat];
        if (widx < 32'(N_IN * N_OUT)) rd_w = w_mem[widx[AW-1:0]];
        if (int'(rd_neuron) < N_OUT) rd_b = b_mem[rd_neuron];
        if (we && sel == CFG_INPUT && int'(addr) == int'(rd_beat)) rd_x = data;
        if (we && sel == CFG_WEIGHT && 32'(addr) == widx) rd_w = data;
        if (we && sel == CFG_BIAS && int'(addr) == int'(rd_neuron)) rd_b = data;
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// rtl/neuron_layer_sequencer.sv - sequences one neuron through N_OUT passes to form a layer
module neuron_layer_sequencer
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int WIDTH   = 15,
    parameter int N_IN    = 8,
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 64,
    localparam int AW     = $clog2(N_IN * N_OUT),
    localparam int JW     = $clog2(N_OUT),
    localparam int KW     = $clog2(N_IN),
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic           clk,
    input  logic           ext_reset,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_sel,
    input  logic [AW-1:0]  cfg_addr,
    input  logic [WIDTH:0] cfg_data,
    input  logic           start,
    input  logic [1:0]     af_sel,
    output logic           busy,
    output logic           done,
    output logic           err,
    input  logic [JW-1:0]  rd_addr,
    output logic [WIDTH:0] rd_data,
    output logic           n_rst,
    output logic [WIDTH:0] n_x,
    output logic [WIDTH:0] n_y,
    output logic [WIDTH:0] n_z,
    output logic           n_af_en,
    output logic [1:0]     n_sel,
    input  logic [WIDTH:0] n_f,
    input  logic           n_complete
);

    state_t         state;
    logic [JW-1:0]  j;
    logic [KW-1:0]  k;
    logic [TW-1:0]  timer;
    logic [WIDTH:0] cap;
    logic [WIDTH:0] result [N_OUT];
    logic [JW-1:0]  rd_neuron;
    logic [KW-1:0]  rd_beat;
    logic [WIDTH:0] mem_x, mem_w, mem_b;
    logic           cfg_ok;

    assign cfg_ok = cfg_we && (state == ST_IDLE);

    seq_param_mem #(.WIDTH(WIDTH), .N_IN(N_IN), .N_OUT(N_OUT)) u_mem (
        .clk       (clk),
        .we        (cfg_ok),
        .sel       (cfg_sel),
        .addr      (cfg_addr),
        .data      (cfg_data),
        .rd_neuron (rd_neuron),
        .rd_beat   (rd_beat),
        .rd_x      (mem_x),
        .rd_w      (mem_w),
        .rd_b      (mem_b)
    );

    // Outputs are registered on entry to a state, so the read port looks one step ahead.
    always_comb begin
        rd_neuron = j;
        rd_beat   = '0;
        case (state)
            ST_IDLE:  rd_neuron = '0;
            ST_STORE: rd_neuron = j + JW'(1);
            ST_FEED:  rd_beat   = k + KW'(1);
            default: ;
        endcase
    end

    assign rd_data = (int'(rd_addr) < N_OUT) ? result[rd_addr] : '0;

    always_ff @(posedge clk) begin
        if (ext_reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            n_rst   <= 1'b0;
            n_af_en <= 1'b0;
            n_x     <= '0;
            n_y     <= '0;
            n_z     <= '0;
            n_sel   <= '0;
            j       <= '0;
            k       <= '0;
            timer   <= '0;
            cap     <= '0;
            for (int i = 0; i < N_OUT; i++) result[i] <= '0;
        end else begin
            done  <= 1'b0;
            n_rst <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_sel <= af_sel;
                        err   <= 1'b0;
                        j     <= '0;
                        busy  <= 1'b1;
                        n_rst <= 1'b1;
                        n_z   <= mem_b;
                        state <= ST_NRST;
                    end
                end
                ST_NRST: begin
                    k     <= '0;
                    n_x   <= mem_x;
                    n_y   <= mem_w;
                    state <= ST_FEED;
                end
                ST_FEED: begin
                    if (k == KW'(N_IN - 1)) begin
                        n_af_en <= 1'b1;
                        timer   <= '0;
                        state   <= ST_WAIT;
                    end else begin
                        k   <= k + KW'(1);
                        n_x <= mem_x;
                        n_y <= mem_w;
                    end
                end
                ST_WAIT: begin
                    if (n_complete) begin
                        cap     <= n_f;
                        n_af_en <= 1'b0;
                        state   <= ST_STORE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        cap     <= '0;
                        err     <= 1'b1;
                        n_af_en <= 1'b0;
                        state   <= ST_STORE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_STORE: begin
                    result[j] <= cap;
                    if (j == JW'(N_OUT - 1)) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        j     <= j + JW'(1);
                        n_rst <= 1'b1;
                        n_z   <= mem_b;
                        state <= ST_NRST;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    n_x   <= '0;
                    n_y   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
